param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//  Parametrised up/down counter. Successor of the fixed 16-bit counter. Adds:
//   configurable width, programmable top, wrap/saturate mode, enable prescaler,
//   terminal-count pulse, sticky overflow/underflow flags and compare-match pulse.
//  Used as the general timer/event-count primitive in the system clock domain.
// PARAMETERS
//  WIDTH      16  counter width in bits (2..32)
//  PSC_W      8   prescaler reload width in bits (1..16)
// PORTS
//  i_sysclk    in   1       system clock, all logic on posedge
//  i_sysrst    in   1       synchronous active-high reset
//  i_ld        in   1       load i_ld_data into counter
//  i_ld_data   in   WIDTH   load value
//  i_clr       in   1       clear counter and prescaler to 0
//  i_cnt_en    in   1       count enable (feeds prescaler)
//  i_dir       in   1       1 = up, 0 = down
//  i_mode      in   1       0 = wrap at boundary, 1 = saturate at boundary
//  i_top       in   WIDTH   upper limit; count range is 0..i_top
//  i_cmp       in   WIDTH   compare value
//  i_psc       in   PSC_W   prescale: one count tick per (i_psc+1) enabled cycles
//  i_flg_clr   in   1       clear sticky o_ovf_flg / o_unf_flg
//  o_cnt       out  WIDTH   counter value (registered)
//  o_tc        out  1       1-cycle pulse on a boundary tick (wrap or saturate)
//  o_ovf_flg   out  1       sticky: set on an up-boundary tick
//  o_unf_flg   out  1       sticky: set on a down-boundary tick
//  o_cmp_hit   out  1       1-cycle pulse: a tick produced a value == i_cmp
// BEHAVIOUR
//  - All outputs are registered. Reset: o_cnt=0, prescaler=0, all flags/pulses=0.
//  - Priority per cycle: i_sysrst > i_ld > i_clr > count tick.
//  - i_ld or i_clr: sets the counter value and resets the prescaler to 0.
//    No o_tc and no o_cmp_hit.
//  - Prescaler r_psc: advances only when i_cnt_en=1 and no ld/clr.
//    tick = (r_psc == i_psc); on a tick r_psc<=0, otherwise r_psc<=r_psc+1.
//    If i_cnt_en=0, r_psc holds. If i_psc=0, a tick occurs every enabled cycle.
//    If r_psc > i_psc (i_psc lowered mid-count), the next enabled cycle is a tick.
//  - Up tick (i_dir=1):
//      cnt < i_top  -> cnt+1.
//      cnt >= i_top -> boundary. Wrap: cnt<=0. Saturate: cnt<=i_top.
//        Boundary sets o_tc=1 and o_ovf_flg=1.
//  - Down tick (i_dir=0):
//      cnt > 0  -> cnt-1. This includes values above i_top after a load.
//      cnt == 0 -> boundary. Wrap: cnt<=i_top. Saturate: hold 0.
//        Boundary sets o_tc=1 and o_unf_flg=1.
//  - o_tc and o_cmp_hit are high exactly one cycle, in the cycle after the tick,
//    together with the new o_cnt. Saturated ticks re-pulse o_tc on every tick.
//  - o_cmp_hit = tick AND next cnt == i_cmp (it fires again on a saturated hold).
//  - Flags: i_flg_clr clears both flags. A set in the same cycle wins (flag stays 1).
//    i_clr and i_ld do not affect the flags.
//  - Arithmetic is modulo 2^WIDTH, with no carry out. i_top, i_cmp and i_psc are
//    sampled live every cycle.
//  - Reset mid-count: all state returns to its reset values next cycle; no pulses.
// TESTING
//  1. WIDTH=16, top=FFFF, psc=0, wrap, ld FFFE, en up for 2 cycles
//       -> o_cnt FFFF then 0000; o_tc=1 and o_ovf_flg=1 on the 0000 cycle.
//  2. top=9, wrap, cnt=0, one down tick
//       -> o_cnt=9, o_unf_flg=1, o_tc pulse; next tick -> 8, no pulse.
//  3. top=5, saturate, up from 3 for 4 ticks
//       -> 4,5,5,5; o_tc on the last two ticks; cmp=5 gives o_cmp_hit on ticks 2-4.
//  4. psc=3, en high 8 cycles, then low 2 cycles, then high 4 cycles
//       -> o_cnt steps every 4th enabled cycle: 1,2, then 3 after the gap.
//  5. ld=1, clr=1, tick all in one cycle with ld_data=0x1234
//       -> o_cnt=0x1234, no o_tc. Then i_flg_clr together with an ovf tick -> flag 1.
//  6. i_sysrst asserted mid-count (cnt=0x0042, ovf=1)
//       -> next cycle o_cnt=0, all flags 0; counting resumes from 0 after release.

Source files
------------

// File: rtl/param_updown_counter.sv
// ============================================================================
// Module      : param_updown_counter
// Description : Parametrised up/down counter with programmable top, wrap or
//               saturate mode, enable prescaler, terminal-count and compare
//               pulses, and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_updown_counter #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_data,
  input  logic             i_clr,
  input  logic             i_cnt_en,
  input  logic             i_dir,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_top,
  input  logic [WIDTH-1:0] i_cmp,
  input  logic [PSC_W-1:0] i_psc,
  input  logic             i_flg_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_ovf_flg,
  output logic             o_unf_flg,
  output logic             o_cmp_hit
);

  localparam logic [WIDTH-1:0] c_CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] c_CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] c_PSC_ZERO = '0;
  localparam logic [PSC_W-1:0] c_PSC_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt_q;
  logic [WIDTH-1:0] w_cnt_d;
  logic [PSC_W-1:0] r_psc_q;
  logic [PSC_W-1:0] w_psc_d;
  logic             r_tc_q;
  logic             w_tc_d;
  logic             r_hit_q;
  logic             w_hit_d;
  logic             r_ovf_q;
  logic             w_ovf_d;
  logic             r_unf_q;
  logic             w_unf_d;

  logic             w_adv;
  logic             w_tick;
  logic             w_up_bnd;
  logic             w_dn_bnd;
  logic             w_ovf_set;
  logic             w_unf_set;

  // Prescaler advances only on enabled cycles not claimed by load/clear.
  // Using >= makes a lowered i_psc tick on the very next enabled cycle.
  assign w_adv    = i_cnt_en & ~i_ld & ~i_clr;
  assign w_tick   = w_adv & (r_psc_q >= i_psc);
  assign w_up_bnd = (r_cnt_q >= i_top);
  assign w_dn_bnd = (r_cnt_q == c_CNT_ZERO);

  always_comb begin
    w_cnt_d   = r_cnt_q;
    w_psc_d   = r_psc_q;
    w_tc_d    = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (i_ld) begin
      w_cnt_d = i_ld_data;
      w_psc_d = c_PSC_ZERO;
    end else if (i_clr) begin
      w_cnt_d = c_CNT_ZERO;
      w_psc_d = c_PSC_ZERO;
    end else if (w_adv) begin
      w_psc_d = w_tick ? c_PSC_ZERO : (r_psc_q + c_PSC_ONE);
      if (w_tick) begin
        if (i_dir) begin
          if (w_up_bnd) begin
            w_cnt_d   = i_mode ? i_top : c_CNT_ZERO;
            w_tc_d    = 1'b1;
            w_ovf_set = 1'b1;
          end else begin
            w_cnt_d = r_cnt_q + c_CNT_ONE;
          end
        end else begin
          if (w_dn_bnd) begin
            w_cnt_d   = i_mode ? c_CNT_ZERO : i_top;
            w_tc_d    = 1'b1;
            w_unf_set = 1'b1;
          end else begin
            w_cnt_d = r_cnt_q - c_CNT_ONE;
          end
        end
      end
    end
  end

  // A flag set in the same cycle as i_flg_clr takes precedence.
  assign w_hit_d = w_tick & (w_cnt_d == i_cmp);
  assign w_ovf_d = w_ovf_set | (r_ovf_q & ~i_flg_clr);
  assign w_unf_d = w_unf_set | (r_unf_q & ~i_flg_clr);

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      r_cnt_q <= c_CNT_ZERO;
      r_psc_q <= c_PSC_ZERO;
      r_tc_q  <= 1'b0;
      r_hit_q <= 1'b0;
      r_ovf_q <= 1'b0;
      r_unf_q <= 1'b0;
    end else begin
      r_cnt_q <= w_cnt_d;
      r_psc_q <= w_psc_d;
      r_tc_q  <= w_tc_d;
      r_hit_q <= w_hit_d;
      r_ovf_q <= w_ovf_d;
      r_unf_q <= w_unf_d;
    end
  end

  assign o_cnt     = r_cnt_q;
  assign o_tc      = r_tc_q;
  assign o_cmp_hit = r_hit_q;
  assign o_ovf_flg = r_ovf_q;
  assign o_unf_flg = r_unf_q;

endmodule

`default_nettype wire

// File: tb/tb_param_updown_counter.sv
// ============================================================================
// Module      : tb_param_updown_counter
// Description : Directed self-checking bench for param_updown_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_updown_counter;

  localparam int WIDTH = 16;
  localparam int PSC_W = 8;

  logic             clk;
  logic             rst;
  logic             r_ld;
  logic [WIDTH-1:0] r_ld_data;
  logic             r_clr;
  logic             r_en;
  logic             r_dir;
  logic             r_mode;
  logic [WIDTH-1:0] r_top;
  logic [WIDTH-1:0] r_cmp;
  logic [PSC_W-1:0] r_psc;
  logic             r_flg_clr;
  logic [WIDTH-1:0] w_cnt;
  logic             w_tc;
  logic             w_ovf;
  logic             w_unf;
  logic             w_hit;

  int checks   = 0;
  int failures = 0;

  param_updown_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) u_dut (
    .i_sysclk  (clk),
    .i_sysrst  (rst),
    .i_ld      (r_ld),
    .i_ld_data (r_ld_data),
    .i_clr     (r_clr),
    .i_cnt_en  (r_en),
    .i_dir     (r_dir),
    .i_mode    (r_mode),
    .i_top     (r_top),
    .i_cmp     (r_cmp),
    .i_psc     (r_psc),
    .i_flg_clr (r_flg_clr),
    .o_cnt     (w_cnt),
    .o_tc      (w_tc),
    .o_ovf_flg (w_ovf),
    .o_unf_flg (w_unf),
    .o_cmp_hit (w_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp4a [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
    int exp4b [4] = '{2, 2, 2, 3};

    rst = 1'b1; r_ld = 1'b0; r_ld_data = '0; r_clr = 1'b0; r_en = 1'b0;
    r_dir = 1'b1; r_mode = 1'b0; r_top = 16'hFFFF; r_cmp = 16'h5555;
    r_psc = '0; r_flg_clr = 1'b0;
    step(); step();
    chk("rst_cnt", 32'(w_cnt), 32'h0);
    chk("rst_tc",  32'(w_tc),  32'h0);
    chk("rst_ovf", 32'(w_ovf), 32'h0);
    chk("rst_unf", 32'(w_unf), 32'h0);
    chk("rst_hit", 32'(w_hit), 32'h0);
    rst = 1'b0;

    // 1: full-range up wrap
    r_ld = 1'b1; r_ld_data = 16'hFFFE;
    step();
    chk("t1_ld", 32'(w_cnt), 32'hFFFE);
    r_ld = 1'b0; r_en = 1'b1; r_dir = 1'b1;
    step();
    chk("t1_cnt_ffff", 32'(w_cnt), 32'hFFFF);
    chk("t1_tc_0",     32'(w_tc),  32'h0);
    chk("t1_ovf_0",    32'(w_ovf), 32'h0);
    step();
    chk("t1_cnt_0000", 32'(w_cnt), 32'h0000);
    chk("t1_tc_1",     32'(w_tc),  32'h1);
    chk("t1_ovf_1",    32'(w_ovf), 32'h1);
    r_en = 1'b0;
    step();
    chk("t1_tc_drop",  32'(w_tc),  32'h0);
    chk("t1_ovf_stk",  32'(w_ovf), 32'h1);

    // 2: down wrap to top
    r_flg_clr = 1'b1;
    step();
    chk("t2_flgclr", 32'(w_ovf), 32'h0);
    r_flg_clr = 1'b0; r_top = 16'd9; r_clr = 1'b1;
    step();
    chk("t2_clr", 32'(w_cnt), 32'h0);
    r_clr = 1'b0; r_en = 1'b1; r_dir = 1'b0;
    step();
    chk("t2_cnt_9", 32'(w_cnt), 32'd9);
    chk("t2_unf",   32'(w_unf), 32'h1);
    chk("t2_tc_1",  32'(w_tc),  32'h1);
    step();
    chk("t2_cnt_8", 32'(w_cnt), 32'd8);
    chk("t2_tc_0",  32'(w_tc),  32'h0);
    r_en = 1'b0;

    // above-top value after a load still counts down
    r_ld = 1'b1; r_ld_data = 16'd20;
    step();
    r_ld = 1'b0; r_en = 1'b1;
    step();
    chk("dn_abovetop", 32'(w_cnt), 32'd19);
    chk("dn_abovetop_tc", 32'(w_tc), 32'h0);
    r_en = 1'b0;

    // 3: saturate up with compare
    r_top = 16'd5; r_mode = 1'b1; r_cmp = 16'd5; r_dir = 1'b1;
    r_ld = 1'b1; r_ld_data = 16'd3;
    step();
    r_ld = 1'b0; r_en = 1'b1;
    step();
    chk("t3_k1_cnt", 32'(w_cnt), 32'd4);
    chk("t3_k1_tc",  32'(w_tc),  32'h0);
    chk("t3_k1_hit", 32'(w_hit), 32'h0);
    step();
    chk("t3_k2_cnt", 32'(w_cnt), 32'd5);
    chk("t3_k2_tc",  32'(w_tc),  32'h0);
    chk("t3_k2_hit", 32'(w_hit), 32'h1);
    step();
    chk("t3_k3_cnt", 32'(w_cnt), 32'd5);
    chk("t3_k3_tc",  32'(w_tc),  32'h1);
    chk("t3_k3_hit", 32'(w_hit), 32'h1);
    step();
    chk("t3_k4_cnt", 32'(w_cnt), 32'd5);
    chk("t3_k4_tc",  32'(w_tc),  32'h1);
    chk("t3_k4_hit", 32'(w_hit), 32'h1);
    r_en = 1'b0;
    step();
    chk("t3_tc_drop",  32'(w_tc),  32'h0);
    chk("t3_hit_drop", 32'(w_hit), 32'h0);

    // 4: prescaler with enable gap
    r_mode = 1'b0; r_top = 16'hFFFF; r_cmp = 16'h5555; r_psc = 8'd3;
    r_clr = 1'b1;
    step();
    r_clr = 1'b0; r_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t4_a%0d", i), 32'(w_cnt), 32'(exp4a[i]));
    end
    r_en = 1'b0;
    step(); step();
    chk("t4_gap", 32'(w_cnt), 32'd2);
    r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t4_b%0d", i), 32'(w_cnt), 32'(exp4b[i]));
    end

    // lowering i_psc below the running prescaler forces the next tick
    step(); step();
    chk("psc_low_pre", 32'(w_cnt), 32'd3);
    r_psc = 8'd1;
    step();
    chk("psc_low_tick", 32'(w_cnt), 32'd4);
    r_en = 1'b0; r_psc = 8'd0;

    // 5: ld beats clr and tick; set beats flag clear
    r_ld = 1'b1; r_clr = 1'b1; r_en = 1'b1; r_ld_data = 16'h1234;
    step();
    chk("t5_ld_cnt", 32'(w_cnt), 32'h1234);
    chk("t5_ld_tc",  32'(w_tc),  32'h0);
    r_ld = 1'b0; r_clr = 1'b0; r_top = 16'h1234; r_flg_clr = 1'b1;
    step();
    chk("t5_wrap_cnt", 32'(w_cnt), 32'h0);
    chk("t5_wrap_tc",  32'(w_tc),  32'h1);
    chk("t5_ovf_wins", 32'(w_ovf), 32'h1);
    chk("t5_unf_clr",  32'(w_unf), 32'h0);
    r_flg_clr = 1'b0; r_en = 1'b0; r_top = 16'hFFFF;

    // 6: reset mid-count
    r_ld = 1'b1; r_ld_data = 16'h0041;
    step();
    r_ld = 1'b0; r_en = 1'b1;
    step();
    chk("t6_pre_cnt", 32'(w_cnt), 32'h0042);
    chk("t6_pre_ovf", 32'(w_ovf), 32'h1);
    rst = 1'b1;
    step();
    chk("t6_rst_cnt", 32'(w_cnt), 32'h0);
    chk("t6_rst_ovf", 32'(w_ovf), 32'h0);
    chk("t6_rst_tc",  32'(w_tc),  32'h0);
    rst = 1'b0;
    step();
    chk("t6_resume", 32'(w_cnt), 32'h1);
    step();
    chk("t6_resume2", 32'(w_cnt), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
